// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state codes and
// the default operand width.
package serial_mag_compare_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // The unused code 2'b11 is handled as IDLE by the controller.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COMPARE = 2'b01,
    S_DONE    = 2'b10
  } state_t;

endpackage

// File: rtl/serial_mag_compare_ctrl_comparator.sv
// Single-bit magnitude comparator cell; exactly one output is high.
module comparator (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);

  assign lt = ~a & b;
  assign gt = a & ~b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Compares two unsigned operands MSB first, one bit per clock, through a single
// comparator cell; stops at the first differing bit and holds the result.
module serial_mag_compare_ctrl
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int IDX_W = $clog2(WIDTH);

  // Handshake: start is accepted only in IDLE with abort low; operands are
  // captured on that edge. done is a one-cycle pulse in DONE; busy covers
  // COMPARE and DONE, and any start seen while busy is dropped.
  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              decide;
  logic              idx_dec;
  logic              cell_lt;
  logic              cell_eq;
  logic              cell_gt;

  comparator u_cell (
    .a  (a_reg[idx]),
    .b  (b_reg[idx]),
    .lt (cell_lt),
    .eq (cell_eq),
    .gt (cell_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        idx   <= IDX_W'(WIDTH - 1);
      end else if (idx_dec) begin
        idx <= idx - IDX_W'(1);
      end
      // On an all-equal final bit the cell already reports eq=1, lt=gt=0.
      if (decide) begin
        lt <= cell_lt;
        eq <= cell_eq;
        gt <= cell_gt;
      end
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    decide     = 1'b0;
    idx_dec    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_COMPARE: begin
        busy = 1'b1;
        if (abort) begin
          next_state = S_IDLE;
        end else if (!cell_eq || idx == '0) begin
          decide     = 1'b1;
          next_state = S_DONE;
        end else begin
          idx_dec = 1'b1;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        if (start && !abort) begin
          accept     = 1'b1;
          next_state = S_COMPARE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl with WIDTH=8: latency, results,
// ignored starts, abort and asynchronous reset.
module tb_serial_mag_compare_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       lt;
  logic       eq;
  logic       gt;

  int checks;
  int passed;

  serial_mag_compare_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .eq    (eq),
    .gt    (gt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
  endtask

  // Cycle count includes the accept cycle: done seen in cycle number cyc.
  task automatic wait_done(input int start_cnt, input int budget,
                           output int cyc, output bit timed_out);
    cyc       = start_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, lt, eq, gt} !== 5'b0) begin
        $display("FAIL reset_idle cycle %0d: busy,done,lt,eq,gt=%b expected 00000", i, {busy, done, lt, eq, gt});
      end else passed++;
    end
  endtask

  task automatic test_gt_msb();
    int cyc;
    bit to;
    start_op(8'hA5, 8'h25);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL gt_msb_compare busy,done=%b%b expected 10", busy, done);
    else passed++;
    @(posedge clk);
    wait_done(2, 20, cyc, to);
    checks++;
    if (to || cyc != 2) $display("FAIL gt_msb_latency got %0d (timeout=%0d) expected 2", cyc, to);
    else passed++;
    checks++;
    if ({busy, lt, eq, gt} !== 4'b1001) $display("FAIL gt_msb_result busy,lt,eq,gt=%b expected 1001", {busy, lt, eq, gt});
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL gt_msb_after busy,done=%b%b expected 00", busy, done);
    else passed++;
  endtask

  task automatic test_eq_then_lt();
    int cyc;
    bit to;
    start_op(8'h3C, 8'h3C);
    wait_done(1, 30, cyc, to);
    checks++;
    if (to || cyc != 9) $display("FAIL eq_latency got %0d (timeout=%0d) expected 9", cyc, to);
    else passed++;
    checks++;
    if ({lt, eq, gt} !== 3'b010) $display("FAIL eq_result lt,eq,gt=%b expected 010", {lt, eq, gt});
    else passed++;
    start_op(8'h10, 8'h11);
    repeat (4) @(negedge clk);
    checks++;
    if ({lt, eq, gt} !== 3'b010) $display("FAIL lt_held_mid lt,eq,gt=%b expected 010", {lt, eq, gt});
    else passed++;
    @(posedge clk);
    wait_done(5, 30, cyc, to);
    checks++;
    if (to || cyc != 9) $display("FAIL lt_latency got %0d (timeout=%0d) expected 9", cyc, to);
    else passed++;
    checks++;
    if ({lt, eq, gt} !== 3'b100) $display("FAIL lt_result lt,eq,gt=%b expected 100", {lt, eq, gt});
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int cyc;
    bit to;
    int extra;
    start_op(8'h01, 8'h02);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(3, 30, cyc, to);
    checks++;
    if (to || cyc != 8) $display("FAIL busy_start_latency got %0d (timeout=%0d) expected 8", cyc, to);
    else passed++;
    checks++;
    if ({lt, eq, gt} !== 3'b100) $display("FAIL busy_start_result lt,eq,gt=%b expected 100", {lt, eq, gt});
    else passed++;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++;
    if (extra != 0) $display("FAIL busy_start_no_second got %0d busy/done cycles expected 0", extra);
    else passed++;
  endtask

  task automatic test_abort();
    int cyc;
    bit to;
    int seen;
    start_op(8'h0F, 8'h0E);
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) seen++;
      @(posedge clk);
    end
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_idle busy=%b expected 0", busy);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL abort_no_done got %0d done cycles expected 0", seen);
    else passed++;
    checks++;
    if ({lt, eq, gt} !== 3'b100) $display("FAIL abort_held lt,eq,gt=%b expected 100", {lt, eq, gt});
    else passed++;
    start_op(8'h80, 8'h00);
    wait_done(1, 20, cyc, to);
    checks++;
    if (to || cyc != 2 || {lt, eq, gt} !== 3'b001)
      $display("FAIL after_abort latency %0d (timeout=%0d) lt,eq,gt=%b expected 2 and 001", cyc, to, {lt, eq, gt});
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    int seen;
    start_op(8'h55, 8'h54);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, lt, eq, gt} !== 5'b0)
      $display("FAIL reset_mid_async busy,done,lt,eq,gt=%b expected 00000", {busy, done, lt, eq, gt});
    else passed++;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL reset_mid_no_done got %0d busy/done cycles expected 0", seen);
    else passed++;
    start_op(8'h55, 8'h54);
    wait_done(1, 30, cyc, to);
    checks++;
    if (to || cyc != 9 || {lt, eq, gt} !== 3'b001)
      $display("FAIL reset_mid_restart latency %0d (timeout=%0d) lt,eq,gt=%b expected 9 and 001", cyc, to, {lt, eq, gt});
    else passed++;
  endtask

  // sequence and report
  initial begin
    checks = 0;
    passed = 0;
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    a      = '0;
    b      = '0;
    test_reset();
    test_gt_msb();
    test_eq_then_lt();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
